// File: rtl/telem_pkg.sv
// Shared constants, state encoding and packet byte mapping for the telemetry transmitter.
// Define TELEM_CHKSUM_EN to append an inverted 8-bit checksum byte to each packet.
package telem_pkg;

  localparam logic [7:0] TELEM_HDR = 8'hA5;

`ifdef TELEM_CHKSUM_EN
  localparam int unsigned NBYTES = 7;
`else
  localparam int unsigned NBYTES = 6;
`endif

  localparam int unsigned IDX_W = $clog2(NBYTES);

  localparam int unsigned FLAG_BATT_LOW  = 0;
  localparam int unsigned FLAG_OVR_SPD   = 1;
  localparam int unsigned FLAG_EN_STEER  = 2;
  localparam int unsigned FLAG_RIDER_OFF = 3;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} telem_st_t;

  typedef struct packed {
    logic [11:0] batt;
    logic [10:0] lft_spd;
    logic [10:0] rght_spd;
    logic        lft_rev;
    logic        rght_rev;
    logic [3:0]  flags;
  } telem_snap_t;

  // Byte k of the packet payload (header plus data bytes; checksum handled by the caller)
  function automatic logic [7:0] pkt_byte(input telem_snap_t s, input logic [IDX_W-1:0] idx);
    case (idx)
      IDX_W'(0): pkt_byte = TELEM_HDR;
      IDX_W'(1): pkt_byte = s.batt[11:4];
      IDX_W'(2): pkt_byte = {s.batt[3:0], s.flags[FLAG_RIDER_OFF], s.flags[FLAG_EN_STEER],
                             s.flags[FLAG_OVR_SPD], s.flags[FLAG_BATT_LOW]};
      IDX_W'(3): pkt_byte = s.lft_spd[10:3];
      IDX_W'(4): pkt_byte = {s.lft_spd[2:0], s.rght_spd[10:6]};
      IDX_W'(5): pkt_byte = {s.rght_spd[5:0], s.lft_rev, s.rght_rev};
      default:   pkt_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/telem_tx_uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, each BAUD_DIV clks.
module uart_tx_byte #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] din,
  output logic       TX,
  output logic       tx_busy,
  output logic       byte_done
);

  localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;

  // byte_done is raised one clk early so it is high during the last clk of the stop bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      TX        <= 1'b1;
      tx_busy   <= 1'b0;
      byte_done <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '1;
    end else begin
      byte_done <= 1'b0;
      if (start) begin
        TX       <= 1'b0;
        shreg    <= {1'b1, din};
        tx_busy  <= 1'b1;
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (tx_busy) begin
        if (bit_cnt == 4'd9 && baud_cnt == BW'(BAUD_DIV - 2))
          byte_done <= 1'b1;
        if (baud_cnt == BW'(BAUD_DIV - 1)) begin
          baud_cnt <= '0;
          if (bit_cnt == 4'd9) begin
            TX      <= 1'b1;
            tx_busy <= 1'b0;
            bit_cnt <= '0;
          end else begin
            TX      <= shreg[0];
            shreg   <= {1'b1, shreg[8:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end else begin
          baud_cnt <= baud_cnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/telem_tx.sv
// Telemetry transmitter: snapshots rider/motor status and sends it as a UART packet.
// Define TELEM_CHKSUM_EN to append B6 = ~(B1+..+B5).
module telem_tx
  import telem_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snap,
  input  logic [11:0] batt,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  input  logic        lft_rev,
  input  logic        rght_rev,
  input  logic [3:0]  flags,
  output logic        TX,
  output logic        busy,
  output logic        pkt_done
);

  telem_st_t        state;
  telem_snap_t      shadow;
  logic [IDX_W-1:0] byte_idx;
  logic [7:0]       cur_byte;
  logic             start_c;
  logic             tx_busy;
  logic             byte_done;
`ifdef TELEM_CHKSUM_EN
  logic [7:0]       csum;
`endif

  // Byte mux over the shadow register
  always_comb begin
    cur_byte = pkt_byte(shadow, byte_idx);
`ifdef TELEM_CHKSUM_EN
    if (byte_idx == IDX_W'(NBYTES - 1))
      cur_byte = ~csum;
`endif
  end

  assign start_c = (state == LOAD) && !tx_busy;

  // Packet sequencer; the LOAD clk sits between consecutive frames with TX idle high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shadow   <= '0;
      byte_idx <= '0;
      busy     <= 1'b0;
      pkt_done <= 1'b0;
`ifdef TELEM_CHKSUM_EN
      csum     <= '0;
`endif
    end else begin
      pkt_done <= 1'b0;
      case (state)
        IDLE: begin
          if (snap) begin
            shadow   <= {batt, lft_spd, rght_spd, lft_rev, rght_rev, flags};
            busy     <= 1'b1;
            byte_idx <= '0;
`ifdef TELEM_CHKSUM_EN
            csum     <= '0;
`endif
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (!tx_busy) begin
`ifdef TELEM_CHKSUM_EN
            if (byte_idx != '0 && byte_idx != IDX_W'(NBYTES - 1))
              csum <= csum + cur_byte;
`endif
            state <= SEND;
          end
        end
        SEND: begin
          if (byte_done) begin
            if (byte_idx == IDX_W'(NBYTES - 1)) begin
              byte_idx <= '0;
              pkt_done <= 1'b1;
              state    <= DONE;
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
              state    <= LOAD;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_c),
    .din       (cur_byte),
    .TX        (TX),
    .tx_busy   (tx_busy),
    .byte_done (byte_done)
  );

endmodule

// File: tb/tb_telem_tx.sv
// Bench for telem_tx: UART RX model sampling mid-bit, checked against a field-level packet model.
module tb_telem_tx;

  localparam int BD = 4;
`ifdef TELEM_CHKSUM_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif
  localparam int BYTE_CLKS = 10 * BD + 1;
  localparam int PKT_CLKS  = NB * BYTE_CLKS;

  logic        clk = 1'b0, rst_n = 1'b1, snap = 1'b0;
  logic [11:0] batt = '0;
  logic [10:0] lft_spd = '0, rght_spd = '0;
  logic        lft_rev = 1'b0, rght_rev = 1'b0;
  logic [3:0]  flags = '0;
  logic        TX, busy, pkt_done;

  int vectors = 0, miscompares = 0, cyc = 0;
  logic [7:0] rx_q[$];
  int st_q[$];
  int done_q[$];
  int glitch = 0, ferr = 0;
  logic [7:0] exp_b [7];

  telem_tx #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .snap(snap), .batt(batt), .lft_spd(lft_spd),
    .rght_spd(rght_spd), .lft_rev(lft_rev), .rght_rev(rght_rev), .flags(flags),
    .TX(TX), .busy(busy), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART receiver: start detect, mid-bit sampling, level held for the whole bit
  initial begin : rx_model
    bit act;
    int cnt;
    logic bitv;
    logic [7:0] sh;
    act = 1'b0; cnt = 0; bitv = 1'b1; sh = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) act = 1'b0;
      else if (!act) begin
        if (TX === 1'b0) begin act = 1'b1; cnt = 0; st_q.push_back(cyc); end
      end else cnt++;
      if (act) begin
        if (cnt % BD == 0) bitv = TX;
        else if (TX !== bitv) glitch++;
        if (cnt % BD == BD / 2 && cnt / BD >= 1 && cnt / BD <= 8) sh[cnt / BD - 1] = TX;
        if (cnt % BD == BD / 2 && cnt / BD == 9 && TX !== 1'b1) ferr++;
        if (cnt == 10 * BD - 1) begin rx_q.push_back(sh); act = 1'b0; end
      end
      if (rst_n && pkt_done === 1'b1) done_q.push_back(cyc);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Packet model from the field layout
  task automatic model(input logic [11:0] b, input logic [10:0] l, input logic [10:0] r,
                       input logic lr, input logic rr, input logic [3:0] f);
    int bi, li, ri, sum;
    bi = int'(b); li = int'(l); ri = int'(r);
    exp_b[0] = 8'hA5;
    exp_b[1] = 8'(bi / 16);
    exp_b[2] = 8'((bi % 16) * 16 + int'(f));
    exp_b[3] = 8'(li / 8);
    exp_b[4] = 8'((li % 8) * 32 + ri / 64);
    exp_b[5] = 8'((ri % 64) * 4 + int'(lr) * 2 + int'(rr));
    sum = 0;
    for (int k = 1; k <= 5; k++) sum += int'(exp_b[k]);
    exp_b[6] = 8'(255 - (sum % 256));
  endtask

  task automatic drive(input logic [11:0] b, input logic [10:0] l, input logic [10:0] r,
                       input logic lr, input logic rr, input logic [3:0] f);
    batt = b; lft_spd = l; rght_spd = r; lft_rev = lr; rght_rev = rr; flags = f;
  endtask

  task automatic drive_rand();
    drive(12'($urandom), 11'($urandom), 11'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
  endtask

  task automatic clear_mon();
    rx_q.delete(); st_q.delete(); done_q.delete(); glitch = 0; ferr = 0;
  endtask

  task automatic pulse_snap(output int s);
    @(negedge clk); snap = 1'b1; s = cyc;
    @(negedge clk); snap = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int p, output int busy_low, output bit to);
    p = -1; busy_low = 0; to = 1'b1;
    for (int i = 0; i < limit; i++) begin
      if (pkt_done === 1'b1) begin p = cyc; to = 1'b0; break; end
      if (busy !== 1'b1) busy_low++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int bad;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (TX !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", TX); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (pkt_done !== 1'b0) begin miscompares++; $display("FAIL reset_pkt_done: got %b want 0", pkt_done); end
    rst_n = 1'b1; bad = 0;
    repeat (100) begin @(negedge clk); if (TX !== 1'b1 || busy !== 1'b0 || pkt_done !== 1'b0) bad++; end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL reset_quiet: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_basic();
    int s, p, bl; bit to;
    logic [7:0] lit [7] = '{8'hA5, 8'hAB, 8'hC5, 8'hFF, 8'hE0, 8'h06, 8'hAA};
    clear_mon();
    drive(12'hABC, 11'h7FF, 11'h001, 1'b1, 1'b0, 4'b0101);
    pulse_snap(s);
    drive_rand();
    wait_done(PKT_CLKS + 40, p, bl, to);
    repeat (3) @(negedge clk);
    vectors++; if (to) begin miscompares++; $display("FAIL basic_timeout: no pkt_done"); end
    vectors++; if (p != s + 1 + PKT_CLKS) begin miscompares++; $display("FAIL basic_done_time: got %0d want %0d", p - s, 1 + PKT_CLKS); end
    vectors++; if (bl != 0) begin miscompares++; $display("FAIL basic_busy: got %0d low cycles want 0", bl); end
    vectors++; if (rx_q.size() != NB) begin miscompares++; $display("FAIL basic_nbytes: got %0d want %0d", rx_q.size(), NB); end
    for (int k = 0; k < NB; k++) begin
      vectors++; if (rx_q[k] !== lit[k]) begin miscompares++; $display("FAIL basic_byte%0d: got %h want %h", k, rx_q[k], lit[k]); end
    end
    vectors++; if (st_q.size() < 1 || st_q[0] != s + 2) begin miscompares++; $display("FAIL basic_latency: start at %0d want %0d", (st_q.size() > 0) ? st_q[0] - s : -1, 2); end
    vectors++; if (glitch != 0 || ferr != 0) begin miscompares++; $display("FAIL basic_frame: got glitch=%0d ferr=%0d want 0", glitch, ferr); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_random();
    int s, p, bl; bit to;
    for (int n = 0; n < 4; n++) begin
      clear_mon();
      drive_rand();
      model(batt, lft_spd, rght_spd, lft_rev, rght_rev, flags);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      pulse_snap(s);
      drive_rand();
      wait_done(PKT_CLKS + 40, p, bl, to);
      repeat (3) @(negedge clk);
      vectors++; if (to || p != s + 1 + PKT_CLKS) begin miscompares++; $display("FAIL rand%0d_done: got %0d want %0d", n, p - s, 1 + PKT_CLKS); end
      vectors++; if (rx_q.size() != NB || bl != 0) begin miscompares++; $display("FAIL rand%0d_len: got %0d bytes busy_low=%0d want %0d", n, rx_q.size(), bl, NB); end
      for (int k = 0; k < NB; k++) begin
        vectors++; if (rx_q[k] !== exp_b[k]) begin miscompares++; $display("FAIL rand%0d_byte%0d: got %h want %h", n, k, rx_q[k], exp_b[k]); end
        vectors++; if (st_q.size() <= k || st_q[k] != s + 2 + k * BYTE_CLKS) begin miscompares++; $display("FAIL rand%0d_start%0d: got %0d want %0d", n, k, (st_q.size() > k) ? st_q[k] - s : -1, 2 + k * BYTE_CLKS); end
      end
      vectors++; if (glitch != 0 || ferr != 0) begin miscompares++; $display("FAIL rand%0d_frame: got glitch=%0d ferr=%0d want 0", n, glitch, ferr); end
    end
  endtask

  task automatic test_snap_busy();
    int s, p, bl; bit to;
    clear_mon();
    drive(12'hABC, 11'h7FF, 11'h001, 1'b1, 1'b0, 4'b0101);
    model(batt, lft_spd, rght_spd, lft_rev, rght_rev, flags);
    pulse_snap(s);
    for (int i = 0; i < 100 && cyc < s + 50; i++) @(negedge clk);
    batt = 12'h123; snap = 1'b1;
    @(negedge clk); snap = 1'b0;
    wait_done(PKT_CLKS + 40, p, bl, to);
    snap = 1'b1;  // lands in the DONE cycle
    @(negedge clk); snap = 1'b0;
    repeat (100) @(negedge clk);
    vectors++; if (to || bl != 0) begin miscompares++; $display("FAIL busy_done: got timeout=%0d busy_low=%0d want 0 0", to, bl); end
    vectors++; if (st_q.size() != NB || rx_q.size() != NB) begin miscompares++; $display("FAIL busy_count: got %0d starts %0d bytes want %0d", st_q.size(), rx_q.size(), NB); end
    vectors++; if (done_q.size() != 1) begin miscompares++; $display("FAIL busy_pkts: got %0d pkt_done pulses want 1", done_q.size()); end
    for (int k = 0; k < NB; k++) begin
      vectors++; if (rx_q[k] !== exp_b[k]) begin miscompares++; $display("FAIL busy_byte%0d: got %h want %h", k, rx_q[k], exp_b[k]); end
    end
  endtask

  task automatic test_back_to_back();
    int s1, s2, p1, p2, bl; bit to1, to2;
    logic [7:0] ea [7];
    clear_mon();
    drive_rand();
    model(batt, lft_spd, rght_spd, lft_rev, rght_rev, flags);
    ea = exp_b;
    pulse_snap(s1);
    drive_rand();
    model(batt, lft_spd, rght_spd, lft_rev, rght_rev, flags);
    wait_done(PKT_CLKS + 40, p1, bl, to1);
    @(negedge clk); snap = 1'b1; s2 = cyc;
    @(negedge clk); snap = 1'b0;
    wait_done(PKT_CLKS + 40, p2, bl, to2);
    repeat (3) @(negedge clk);
    vectors++; if (to1 || to2) begin miscompares++; $display("FAIL b2b_timeout: got %0d %0d want 0 0", to1, to2); end
    vectors++; if (st_q.size() != 2 * NB || rx_q.size() != 2 * NB) begin miscompares++; $display("FAIL b2b_count: got %0d starts %0d bytes want %0d", st_q.size(), rx_q.size(), 2 * NB); end
    vectors++; if (st_q.size() > NB && st_q[NB] != p1 + 3) begin miscompares++; $display("FAIL b2b_restart: got %0d want %0d", st_q[NB] - p1, 3); end
    vectors++; if (p2 != s2 + 1 + PKT_CLKS) begin miscompares++; $display("FAIL b2b_done2: got %0d want %0d", p2 - s2, 1 + PKT_CLKS); end
    for (int k = 0; k < NB; k++) begin
      vectors++; if (rx_q[k] !== ea[k]) begin miscompares++; $display("FAIL b2b_p1_byte%0d: got %h want %h", k, rx_q[k], ea[k]); end
      vectors++; if (rx_q[NB + k] !== exp_b[k]) begin miscompares++; $display("FAIL b2b_p2_byte%0d: got %h want %h", k, rx_q[NB + k], exp_b[k]); end
    end
    for (int k = 1; k < st_q.size(); k++) begin
      if (k == NB) continue;
      vectors++; if (st_q[k] - st_q[k - 1] != BYTE_CLKS) begin miscompares++; $display("FAIL b2b_spacing%0d: got %0d want %0d", k, st_q[k] - st_q[k - 1], BYTE_CLKS); end
    end
    vectors++; if (glitch != 0 || ferr != 0) begin miscompares++; $display("FAIL b2b_frame: got glitch=%0d ferr=%0d want 0", glitch, ferr); end
  endtask

  task automatic test_reset_mid();
    int s, p, bl, target; bit to;
    clear_mon();
    drive(12'hABC, 11'h7FF, 11'h001, 1'b1, 1'b0, 4'b0101);
    pulse_snap(s);
    target = s + 2 + 2 * BYTE_CLKS + 5 * BD + 1;  // inside data bit 4 of B2 (8'hC5 -> 0)
    for (int i = 0; i < 1000 && cyc < target; i++) @(negedge clk);
    vectors++; if (TX !== 1'b0) begin miscompares++; $display("FAIL mid_pre_tx: got %b want 0", TX); end
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (TX !== 1'b1) begin miscompares++; $display("FAIL mid_rst_tx: got %b want 1", TX); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    clear_mon();
    drive_rand();
    model(batt, lft_spd, rght_spd, lft_rev, rght_rev, flags);
    pulse_snap(s);
    wait_done(PKT_CLKS + 40, p, bl, to);
    repeat (3) @(negedge clk);
    vectors++; if (to || p != s + 1 + PKT_CLKS || bl != 0) begin miscompares++; $display("FAIL mid_after_done: got %0d busy_low=%0d want %0d", p - s, bl, 1 + PKT_CLKS); end
    vectors++; if (rx_q.size() != NB) begin miscompares++; $display("FAIL mid_after_len: got %0d want %0d", rx_q.size(), NB); end
    for (int k = 0; k < NB; k++) begin
      vectors++; if (rx_q[k] !== exp_b[k]) begin miscompares++; $display("FAIL mid_after_byte%0d: got %h want %h", k, rx_q[k], exp_b[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_snap_busy();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
